// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data memory arbiter: FSM state encoding,
// access size and port index constants, and read-byte reassembly.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB       = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;

  // Rebuild the 16-bit read word from the two bank bytes. Byte reads are
  // zero-extended; the processor does its own sign extension.
  function automatic logic [15:0] assemble_rdata(input logic       half,
                                                 input logic       a0,
                                                 input logic [7:0] even_b,
                                                 input logic [7:0] odd_b);
    logic [15:0] word;
    word = 16'h0000;
    if (half == SIZE_HALF) begin
      if (a0) word = {even_b, odd_b};
      else    word = {odd_b, even_b};
    end else begin
      if (a0) word = {8'h00, odd_b};
      else    word = {8'h00, even_b};
    end
    return word;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_bank_steer.sv
// Byte-to-bank steering for one granted access: computes bank word addresses,
// write bytes and write enables, and reassembles read bytes from the registered
// read context.
module bank_steer #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic                  half_i,
  input  logic [ADDR_WIDTH:0]   addr_i,
  input  logic [15:0]           wdata_i,
  output logic                  even_we_o,
  output logic                  odd_we_o,
  output logic [ADDR_WIDTH-1:0] even_addr_o,
  output logic [ADDR_WIDTH-1:0] odd_addr_o,
  output logic [7:0]            even_wdata_o,
  output logic [7:0]            odd_wdata_o,
  input  logic                  rd_half_i,
  input  logic                  rd_a0_i,
  input  logic [7:0]            even_rdata_i,
  input  logic [7:0]            odd_rdata_i,
  output logic [15:0]           rdata_o
);
  import mem_arb_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic                  a0_s;
  logic                  even_touch_s;
  logic                  odd_touch_s;
  logic [ADDR_WIDTH-1:0] word_s;

  // Map the byte address onto the banks; an odd halfword spills its high
  // byte into the even bank at the next word, wrapping at the top.
  always_comb begin
    a0_s         = addr_i[0];
    word_s       = addr_i[ADDR_WIDTH:1];
    odd_addr_o   = word_s;
    even_addr_o  = word_s;
    even_wdata_o = 8'h00;
    odd_wdata_o  = 8'h00;
    if (a0_s) even_addr_o = word_s + ADDR_ONE;
    else      even_addr_o = word_s;
    even_touch_s = (half_i == SIZE_HALF) | ~a0_s;
    odd_touch_s  = (half_i == SIZE_HALF) | a0_s;
    case ({half_i, a0_s})
      2'b00: begin even_wdata_o = wdata_i[7:0];  odd_wdata_o = 8'h00;         end
      2'b01: begin even_wdata_o = 8'h00;         odd_wdata_o = wdata_i[7:0];  end
      2'b10: begin even_wdata_o = wdata_i[7:0];  odd_wdata_o = wdata_i[15:8]; end
      2'b11: begin even_wdata_o = wdata_i[15:8]; odd_wdata_o = wdata_i[7:0];  end
      default: begin even_wdata_o = 8'h00;       odd_wdata_o = 8'h00;         end
    endcase
    even_we_o = en_i & we_i & even_touch_s;
    odd_we_o  = en_i & we_i & odd_touch_s;
  end

  // Steer the bank read bytes back into a word using the captured context.
  always_comb begin
    rdata_o = assemble_rdata(rd_half_i, rd_a0_i, even_rdata_i, odd_rdata_i);
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the even/odd byte-banked data memory: round-robin
// between the processor and the DMA engine with a bounded DMA burst lock,
// byte/halfword steering and one-cycle read responses.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH:0]   addr0_i,
  input  logic [ADDR_WIDTH:0]   addr1_i,
  input  logic [15:0]           wdata0_i,
  input  logic [15:0]           wdata1_i,
  input  logic                  dma_lock_i,
  output logic [1:0]            gnt_o,
  output logic                  stall_cpu_o,
  output logic [1:0]            rvalid_o,
  output logic [15:0]           rdata_o,
  output logic                  even_we_o,
  output logic                  odd_we_o,
  output logic [ADDR_WIDTH-1:0] even_addr_o,
  output logic [ADDR_WIDTH-1:0] odd_addr_o,
  output logic [7:0]            even_wdata_o,
  output logic [7:0]            odd_wdata_o,
  input  logic [7:0]            even_rdata_i,
  input  logic [7:0]            odd_rdata_i
);
  import mem_arb_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  arb_state_t            state_q, state_d;
  logic                  last_dma_q, last_dma_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  rd_half_q, rd_half_d;
  logic                  rd_a0_q, rd_a0_d;
  logic [ADDR_WIDTH-1:0] even_addr_q, even_addr_d;
  logic [ADDR_WIDTH-1:0] odd_addr_q, odd_addr_d;

  logic [1:0]            gnt_s;
  logic                  any_gnt_s;
  logic                  acc_we_s;
  logic                  acc_half_s;
  logic [ADDR_WIDTH:0]   acc_addr_s;
  logic [15:0]           acc_wdata_s;
  logic [ADDR_WIDTH-1:0] st_even_addr_s;
  logic [ADDR_WIDTH-1:0] st_odd_addr_s;
  logic [15:0]           rd_word_s;

  // Grant decision: round-robin on ties in ARB, DMA-only while a burst holds.
  always_comb begin
    gnt_s = 2'b00;
    if (reset) begin
      gnt_s = 2'b00;
    end else begin
      case (state_q)
        ARB: begin
          case (req_i)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = last_dma_q ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
          endcase
        end
        DMA_BURST: gnt_s = req_i[PORT_DMA] ? 2'b10 : 2'b00;
        default:   gnt_s = 2'b00;
      endcase
    end
  end

  // Burst tracking: enter on a locked DMA grant, leave on unlock, idle DMA or cap.
  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB: begin
        if (gnt_s != 2'b00) last_dma_d = gnt_s[PORT_DMA];
        else                last_dma_d = last_dma_q;
        if (gnt_s[PORT_DMA] && dma_lock_i && (MAX_BURST > 1)) begin
          state_d    = DMA_BURST;
          beat_cnt_d = CNT_ONE;
        end else begin
          state_d    = ARB;
          beat_cnt_d = CNT_ZERO;
        end
      end
      DMA_BURST: begin
        last_dma_d = 1'b1;
        if (gnt_s[PORT_DMA]) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
          if (!dma_lock_i || (beat_cnt_d == CNT_MAX)) begin
            state_d    = ARB;
            beat_cnt_d = CNT_ZERO;
          end else begin
            state_d = DMA_BURST;
          end
        end else begin
          state_d    = ARB;
          beat_cnt_d = CNT_ZERO;
        end
      end
      default: begin
        state_d    = ARB;
        beat_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Select the winning port's access fields.
  always_comb begin
    any_gnt_s = |gnt_s;
    if (gnt_s[PORT_DMA]) begin
      acc_addr_s  = addr1_i;
      acc_wdata_s = wdata1_i;
      acc_we_s    = we_i[PORT_DMA];
      acc_half_s  = size_i[PORT_DMA];
    end else begin
      acc_addr_s  = addr0_i;
      acc_wdata_s = wdata0_i;
      acc_we_s    = we_i[PORT_CPU];
      acc_half_s  = size_i[PORT_CPU];
    end
  end

  bank_steer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_steer (
    .en_i         (any_gnt_s),
    .we_i         (acc_we_s),
    .half_i       (acc_half_s),
    .addr_i       (acc_addr_s),
    .wdata_i      (acc_wdata_s),
    .even_we_o    (even_we_o),
    .odd_we_o     (odd_we_o),
    .even_addr_o  (st_even_addr_s),
    .odd_addr_o   (st_odd_addr_s),
    .even_wdata_o (even_wdata_o),
    .odd_wdata_o  (odd_wdata_o),
    .rd_half_i    (rd_half_q),
    .rd_a0_i      (rd_a0_q),
    .even_rdata_i (even_rdata_i),
    .odd_rdata_i  (odd_rdata_i),
    .rdata_o      (rd_word_s)
  );

  // Hold bank addresses across idle cycles and capture the read context.
  always_comb begin
    rvalid_d = {gnt_s[PORT_DMA] & ~we_i[PORT_DMA], gnt_s[PORT_CPU] & ~we_i[PORT_CPU]};
    if (any_gnt_s) begin
      even_addr_d = st_even_addr_s;
      odd_addr_d  = st_odd_addr_s;
      rd_half_d   = acc_half_s;
      rd_a0_d     = acc_addr_s[0];
    end else begin
      even_addr_d = even_addr_q;
      odd_addr_d  = odd_addr_q;
      rd_half_d   = rd_half_q;
      rd_a0_d     = rd_a0_q;
    end
  end

  // Drive the externally visible outputs; reset forces them quiet.
  always_comb begin
    gnt_o       = gnt_s;
    stall_cpu_o = req_i[PORT_CPU] & ~gnt_s[PORT_CPU];
    if (reset) begin
      even_addr_o = ADDR_ZERO;
      odd_addr_o  = ADDR_ZERO;
      rvalid_o    = 2'b00;
      rdata_o     = 16'h0000;
    end else begin
      even_addr_o = even_addr_d;
      odd_addr_o  = odd_addr_d;
      rvalid_o    = rvalid_q;
      if (rvalid_q != 2'b00) rdata_o = rd_word_s;
      else                   rdata_o = 16'h0000;
    end
  end

  // State and read-context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      last_dma_q  <= 1'b1;
      beat_cnt_q  <= CNT_ZERO;
      rvalid_q    <= 2'b00;
      rd_half_q   <= 1'b0;
      rd_a0_q     <= 1'b0;
      even_addr_q <= ADDR_ZERO;
      odd_addr_q  <= ADDR_ZERO;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      beat_cnt_q  <= beat_cnt_d;
      rvalid_q    <= rvalid_d;
      rd_half_q   <= rd_half_d;
      rd_a0_q     <= rd_a0_d;
      even_addr_q <= even_addr_d;
      odd_addr_q  <= odd_addr_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a random
// run against a byte-addressed memory model and a rule-level arbiter model.
module tb_data_mem_arbiter;
  localparam int AW   = 17;
  localparam int AW1  = AW + 1;
  localparam int MB   = 16;
  localparam int NB   = 1 << AW1;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, we, size;
  logic [AW:0]   addr0, addr1;
  logic [15:0]   wdata0, wdata1;
  logic          lock;
  logic [1:0]    gnt, rvalid;
  logic          stall;
  logic [15:0]   rdata;
  logic          even_we, odd_we;
  logic [AW-1:0] even_addr, odd_addr;
  logic [7:0]    even_wdata, odd_wdata;
  logic [7:0]    even_rd, odd_rd;

  logic [7:0] mem_e   [0:NW-1];
  logic [7:0] mem_o   [0:NW-1];
  logic [7:0] ref_mem [0:NB-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .size_i(size),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .dma_lock_i(lock), .gnt_o(gnt), .stall_cpu_o(stall), .rvalid_o(rvalid),
    .rdata_o(rdata), .even_we_o(even_we), .odd_we_o(odd_we),
    .even_addr_o(even_addr), .odd_addr_o(odd_addr),
    .even_wdata_o(even_wdata), .odd_wdata_o(odd_wdata),
    .even_rdata_i(even_rd), .odd_rdata_i(odd_rd)
  );

  // Synchronous-read bank pair.
  always @(posedge clk) begin
    if (even_we) mem_e[even_addr] <= even_wdata;
    if (odd_we)  mem_o[odd_addr]  <= odd_wdata;
    even_rd <= mem_e[even_addr];
    odd_rd  <= mem_o[odd_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00; size = 2'b00; lock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [AW:0] rnd_addr();
    logic [AW:0] a;
    if ($urandom_range(0, 3) == 0) a = AW1'(NB - 1 - int'($urandom_range(0, 3)));
    else                           a = AW1'($urandom);
    return a;
  endfunction

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; we = 2'b11; size = 2'b11; lock = 1'b1;
    addr0 = 18'h12345; addr1 = 18'h2ABCD; wdata0 = 16'h1111; wdata1 = 16'h2222;
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", rvalid); end
    total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
    total++; if ({even_we, odd_we} !== 2'b00) begin bad++; $display("FAIL reset_we got=%b want=00", {even_we, odd_we}); end
    total++; if (even_addr !== 17'h0 || odd_addr !== 17'h0) begin bad++; $display("FAIL reset_addr got=%h/%h want=0/0", even_addr, odd_addr); end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    req = 2'b11; we = 2'b00; size = 2'b00; lock = 1'b0; addr0 = 18'h0; addr1 = 18'h2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_g = (c % 2 == 1) ? 2'b01 : 2'b10;
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL contention_gnt c=%0d got=%b want=%b", c, gnt, exp_g); end
      total++; if (stall !== (c % 2 == 0)) begin bad++; $display("FAIL contention_stall c=%0d got=%b want=%b", c, stall, (c % 2 == 0)); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_half_store_load();
    req = 2'b01; we = 2'b01; size = 2'b01; addr0 = 18'h00005; wdata0 = 16'hBEEF;
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL hst_gnt got=%b want=01", gnt); end
    total++; if ({odd_we, odd_addr, odd_wdata} !== {1'b1, 17'h2, 8'hEF}) begin bad++; $display("FAIL hst_odd got=%b/%h/%h want=1/2/ef", odd_we, odd_addr, odd_wdata); end
    total++; if ({even_we, even_addr, even_wdata} !== {1'b1, 17'h3, 8'hBE}) begin bad++; $display("FAIL hst_even got=%b/%h/%h want=1/3/be", even_we, even_addr, even_wdata); end
    ref_mem[5] = 8'hEF; ref_mem[6] = 8'hBE;
    next_cycle();
    we = 2'b00;
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL hld_gnt got=%b want=01", gnt); end
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL hst_no_rvalid got=%b want=00", rvalid); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL hld_rvalid got=%b want=01", rvalid); end
    total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL hld_rdata got=%h want=beef", rdata); end
    total++; if (even_addr !== 17'h3 || odd_addr !== 17'h2) begin bad++; $display("FAIL addr_hold got=%h/%h want=3/2", even_addr, odd_addr); end
    next_cycle();
  endtask

  task automatic test_burst_cap();
    logic [1:0] exp_g;
    req = 2'b11; we = 2'b00; size = 2'b00; lock = 1'b1; addr0 = 18'h10; addr1 = 18'h40;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_g = (c <= MB) ? 2'b10 : 2'b01;
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL burst_gnt c=%0d got=%b want=%b", c, gnt, exp_g); end
      if (c <= MB) begin
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL burst_stall c=%0d got=%b want=1", c, stall); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_d;
    req = 2'b01; we = 2'b00; size = 2'b01; addr0 = 18'h3FFFF;
    exp_d = {ref_mem[0], ref_mem[NB-1]};
    @(negedge clk);
    total++; if (odd_addr !== 17'h1FFFF || even_addr !== 17'h00000) begin bad++; $display("FAIL wrap_addr got=%h/%h want=1ffff/0", odd_addr, even_addr); end
    total++; if ({even_we, odd_we} !== 2'b00) begin bad++; $display("FAIL wrap_we got=%b want=00", {even_we, odd_we}); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid !== 2'b01 || rdata !== exp_d) begin bad++; $display("FAIL wrap_rdata got=%b/%h want=01/%h", rvalid, rdata, exp_d); end
    next_cycle();
  endtask

  task automatic test_byte_read();
    req = 2'b01; we = 2'b01; size = 2'b00; addr0 = 18'h00101; wdata0 = 16'h559C;
    @(negedge clk);
    total++; if ({odd_we, odd_addr, odd_wdata} !== {1'b1, 17'h80, 8'h9C}) begin bad++; $display("FAIL bwr_odd got=%b/%h/%h want=1/80/9c", odd_we, odd_addr, odd_wdata); end
    total++; if (even_we !== 1'b0) begin bad++; $display("FAIL bwr_even_we got=%b want=0", even_we); end
    ref_mem[18'h00101] = 8'h9C;
    next_cycle();
    we = 2'b00;
    @(negedge clk);
    total++; if (gnt !== 2'b01 || {even_we, odd_we} !== 2'b00) begin bad++; $display("FAIL brd_req got=%b/%b want=01/00", gnt, {even_we, odd_we}); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid !== 2'b01 || rdata !== 16'h009C) begin bad++; $display("FAIL brd_rdata got=%b/%h want=01/009c", rvalid, rdata); end
    total++; if (even_we !== 1'b0) begin bad++; $display("FAIL brd_even_we got=%b want=0", even_we); end
    next_cycle();
  endtask

  task automatic test_random();
    int m_last_dma, m_burst, m_cnt, p, h, w, b, e_t, o_t;
    logic [1:0]  g, pend_rv;
    logic [15:0] pend_rd, wd;
    logic [AW:0] a;
    logic [7:0]  val;
    do_reset();
    m_last_dma = 1; m_burst = 0; m_cnt = 0; pend_rv = 2'b00; pend_rd = 16'h0;
    for (int n = 0; n < 500; n++) begin
      req = 2'($urandom); we = 2'($urandom); size = 2'($urandom);
      lock = ($urandom_range(0, 9) < 7);
      addr0 = rnd_addr(); addr1 = rnd_addr();
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      @(negedge clk);
      total++; if (rvalid !== pend_rv) begin bad++; $display("FAIL rnd_rvalid n=%0d got=%b want=%b", n, rvalid, pend_rv); end
      if (pend_rv != 2'b00) begin
        total++; if (rdata !== pend_rd) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, rdata, pend_rd); end
      end
      if (m_burst != 0)      g = req[1] ? 2'b10 : 2'b00;
      else if (req == 2'b11) g = (m_last_dma != 0) ? 2'b01 : 2'b10;
      else                   g = req;
      total++; if (gnt !== g) begin bad++; $display("FAIL rnd_gnt n=%0d got=%b want=%b", n, gnt, g); end
      total++; if (stall !== (req[0] & ~g[0])) begin bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall, req[0] & ~g[0]); end
      pend_rv = 2'b00;
      if (g != 2'b00) begin
        p  = g[1] ? 1 : 0;
        a  = p ? addr1 : addr0;
        wd = p ? wdata1 : wdata0;
        h  = size[p] ? 1 : 0;
        w  = we[p] ? 1 : 0;
        e_t = 0; o_t = 0;
        if (w == 0) begin
          pend_rv = p ? 2'b10 : 2'b01;
          pend_rd = h ? {ref_mem[(int'(a) + 1) % NB], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        for (int k = 0; k <= h; k++) begin
          b   = (int'(a) + k) % NB;
          val = (k == 0) ? wd[7:0] : wd[15:8];
          if (b % 2 == 0) begin
            e_t = 1;
            total++; if (even_addr !== AW'(b / 2)) begin bad++; $display("FAIL rnd_even_addr n=%0d got=%h want=%h", n, even_addr, b / 2); end
            if (w != 0) begin
              total++; if (even_wdata !== val) begin bad++; $display("FAIL rnd_even_wdata n=%0d got=%h want=%h", n, even_wdata, val); end
            end
          end else begin
            o_t = 1;
            total++; if (odd_addr !== AW'(b / 2)) begin bad++; $display("FAIL rnd_odd_addr n=%0d got=%h want=%h", n, odd_addr, b / 2); end
            if (w != 0) begin
              total++; if (odd_wdata !== val) begin bad++; $display("FAIL rnd_odd_wdata n=%0d got=%h want=%h", n, odd_wdata, val); end
            end
          end
          if (w != 0) ref_mem[b] = val;
        end
        total++; if ({even_we, odd_we} !== {1'(w & e_t), 1'(w & o_t)}) begin bad++; $display("FAIL rnd_we n=%0d got=%b want=%b%b", n, {even_we, odd_we}, 1'(w & e_t), 1'(w & o_t)); end
      end else begin
        total++; if ({even_we, odd_we} !== 2'b00) begin bad++; $display("FAIL rnd_idle_we n=%0d got=%b want=00", n, {even_we, odd_we}); end
      end
      if (m_burst != 0) begin
        if (g[1]) begin
          m_cnt++;
          if (!lock || m_cnt == MB) m_burst = 0;
        end else begin
          m_burst = 0;
        end
        m_last_dma = 1;
      end else if (g != 2'b00) begin
        m_last_dma = g[1] ? 1 : 0;
        if (g[1] && lock && MB > 1) begin m_burst = 1; m_cnt = 1; end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 2'b10; we = 2'b00; size = 2'b11; lock = 1'b1; addr1 = 18'h00100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rmb_gnt c=%0d got=%b want=10", c, gnt); end
      next_cycle();
      addr1 = AW1'(18'h00100 + 4 * c);
    end
    reset = 1'b1; req = 2'b11; we = 2'b11;
    for (int c = 5; c <= 6; c++) begin
      @(negedge clk);
      total++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin bad++; $display("FAIL rmb_quiet c=%0d got=%b/%b want=00/00", c, gnt, rvalid); end
      total++; if ({even_we, odd_we} !== 2'b00) begin bad++; $display("FAIL rmb_we c=%0d got=%b want=00", c, {even_we, odd_we}); end
      next_cycle();
    end
    reset = 1'b0; req = 2'b11; we = 2'b00; lock = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rmb_first_tie got=%b want=01", gnt); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    addr0 = '0; addr1 = '0; wdata0 = 16'h0; wdata1 = 16'h0;
    for (int i = 0; i < NW; i++) begin
      mem_e[i] = 8'($urandom);
      mem_o[i] = 8'($urandom);
      ref_mem[2*i]   = mem_e[i];
      ref_mem[2*i+1] = mem_o[i];
    end
    test_reset();
    test_contention();
    test_half_store_load();
    test_burst_cap();
    test_wrap();
    test_byte_read();
    test_random();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the dual-bank data memory (even/odd byte banks, synchronous read) between two requesters:
  - port 0: the processor load/store stage;
  - port 1: a DMA/loader engine used for framebuffer fills.
- Splits byte and halfword accesses across the two banks and steers read bytes back.
- Grants the banks round-robin, with a bounded DMA burst lock.
- The VGA read port of the banks is outside this block and untouched.

Parameters:
- ADDR_WIDTH, 17, bank word-address width; the byte address is ADDR_WIDTH+1 bits.
- MAX_BURST, 16, maximum consecutive DMA beats under lock (>=1).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  2  request per port; bit 0 is the processor, bit 1 is DMA.
- we_i  in  2  write enable per port.
- size_i  in  2  per port: 0 = byte, 1 = halfword.
- addr0_i, addr1_i  in  ADDR_WIDTH+1  byte addresses.
- wdata0_i, wdata1_i  in  16  write data; the low byte is used for byte stores.
- dma_lock_i  in  1  DMA requests to keep the banks for consecutive beats.
- gnt_o  out  2  one-hot grant, same cycle as req (combinational from state and req).
- stall_cpu_o  out  1  equals req_i[0] & ~gnt_o[0].
- rvalid_o  out  2  read-data valid, one cycle after a granted read.
- rdata_o  out  16  read data, meaningful when rvalid_o is nonzero.
- even_we_o, odd_we_o  out  1  bank write enables.
- even_addr_o, odd_addr_o  out  ADDR_WIDTH  bank word addresses.
- even_wdata_o, odd_wdata_o  out  8  bank write bytes.
- even_rdata_i, odd_rdata_i  in  8  bank read bytes, one-cycle latency.

Behaviour:
- **Reset:**
  - gnt_o=0, rvalid_o=0, rdata_o=0, all bank write enables 0, bank addresses 0.
  - FSM enters ARB, last_grant is set to DMA (so the processor wins the first tie), beat_cnt=0.
  - Reset mid-burst or with a read in flight drops the pending rvalid; no bank write is issued in the reset cycle.
- **States:** ARB, DMA_BURST.
- **ARB:**
  - With a single requester, that requester is granted.
  - With both requesting, grant goes to the port that is not last_grant.
  - Grant to DMA with dma_lock_i=1 moves to DMA_BURST with beat_cnt=1.
  - last_grant updates on every grant.
- **DMA_BURST:**
  - DMA is granted whenever req_i[1]=1; the processor is stalled.
  - beat_cnt increments per DMA grant.
  - Return to ARB when any of these holds: dma_lock_i=0, req_i[1]=0, or beat_cnt==MAX_BURST after that grant.
  - On exit last_grant=DMA, so a waiting processor is granted next cycle.
- **Throughput:** one access per cycle, no bubbles between back-to-back grants.
- **Bank mapping, with A = byte address and W = A>>1:**
  - Byte at even A: even bank at W.
  - Byte at odd A: odd bank at W.
  - Halfword at even A: low byte in even bank at W, high byte in odd bank at W.
  - Halfword at odd A: low byte in odd bank at W, high byte in even bank at W+1.
  - W+1 wraps modulo 2^ADDR_WIDTH; the top address wraps to 0.
  - Writes drive only the banks touched; a byte write never asserts the other bank's write enable.
  - Bank address outputs hold their previous value when there is no grant.
- **Reads:**
  - Register the port, size and A[0] at grant.
  - Next cycle, pulse rvalid_o for that port.
  - rdata_o for a byte read = {8'h00, selected byte}; zero-extension only, because sign extension is the processor's job.
  - rdata_o for a halfword read = {high byte, low byte} per the mapping above.
- **Writes:** produce no rvalid.
- **Overlap:** a read granted in cycle N and a new grant in cycle N+1 are independent; the response for N appears in N+1 regardless of the N+1 grant.
- **Unused request fields:** size_i values 2 and 3 are treated as halfword.

Decomposition:
- **Package mem_arb_pkg:**
  - arb_state_t enum {ARB, DMA_BURST};
  - access size constants SIZE_BYTE=0, SIZE_HALF=1;
  - port index constants PORT_CPU=0, PORT_DMA=1.
- **Sub-module bank_steer:** combinational byte-to-bank address/data/write-enable steering and read-byte reassembly. It is instanced once for the request path, and its reassembly function is used on the registered read context.

Test Plan:
- **Processor halfword store then load:**
  - Stimulus: processor only; store half 16'hBEEF to A=0x0005, then load half at 0x0005.
  - Response for the store: odd bank addr 2 gets 8'hEF, even bank addr 3 gets 8'hBE.
  - Response for the load: rvalid_o=2'b01 one cycle later with rdata_o=16'hBEEF.
- **Contention:**
  - Stimulus: both ports request continuously for 6 cycles starting after reset, no lock.
  - Response: gnt_o alternates 01,10,01,10,01,10; stall_cpu_o=1 in cycles 2, 4 and 6.
- **Burst cap:**
  - Stimulus: DMA holds dma_lock_i=1 with continuous requests while the processor requests, MAX_BURST=16.
  - Response: DMA granted 16 consecutive cycles, then the processor is granted in cycle 17.
- **Wrap:**
  - Stimulus: halfword read at A=2^18-1.
  - Response: low byte from odd bank at 0x1FFFF, high byte from even bank at 0x00000.
- **Byte read:**
  - Stimulus: byte read at odd A with odd byte 8'h9C.
  - Response: rdata_o=16'h009C, and even_we_o stays 0 throughout.
- **Reset mid-burst:**
  - Stimulus: reset asserted in cycle 5 of a DMA read burst.
  - Response: the next cycle has rvalid_o=0 and gnt_o=0; after reset release a tied request grants the processor first.
